// File: rtl/his_bank_scheduler.sv
// his_bank_scheduler
// Round-robin arbiter that funnels TDC timestamp requests onto the single
// write port of a ping-pong histogram RAM. It tracks input/pixel/acquisition
// position, swaps banks at frame end and hands the finished bank to readout.
// Optional feature macro: HIS_BANK_CLEAR_EN -- when defined, a CLEAR state
// sweeps zeros through the write bank after every handoff and after reset.
module his_bank_scheduler #(
    parameter int N_REQ     = 4,
    parameter int NB        = 8,
    parameter int DATA_NUM  = 2,
    parameter int PIXEL_NUM = 200,
    parameter int ACQ_NUM   = 33333
) (
    input  logic                         clk,
    input  logic                         res,
    input  logic [N_REQ-1:0]             req,
    input  logic [N_REQ*NB-1:0]          req_addr,
    output logic [N_REQ-1:0]             gnt,
    output logic                         ram_we,
    output logic                         ram_clr,
    output logic                         ram_bank,
    output logic [$clog2(PIXEL_NUM)-1:0] ram_pix,
    output logic [NB-1:0]                ram_bin,
    output logic                         rd_start,
    output logic                         rd_bank,
    input  logic                         rd_done,
    output logic                         frame_done,
    output logic                         stall
);

    localparam int RW = (N_REQ > 1)    ? $clog2(N_REQ)    : 1;
    localparam int IW = (DATA_NUM > 1) ? $clog2(DATA_NUM) : 1;
    localparam int PW = $clog2(PIXEL_NUM);
    localparam int AW = (ACQ_NUM > 1)  ? $clog2(ACQ_NUM)  : 1;

    localparam logic [RW-1:0] REQ_LAST = RW'(N_REQ - 1);
    localparam logic [IW-1:0] IN_LAST  = IW'(DATA_NUM - 1);
    localparam logic [PW-1:0] PIX_LAST = PW'(PIXEL_NUM - 1);
    localparam logic [AW-1:0] ACQ_LAST = AW'(ACQ_NUM - 1);

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_WAIT  = 2'd1,
        S_CLEAR = 2'd2
    } state_t;

`ifdef HIS_BANK_CLEAR_EN
    localparam state_t ENTRY_STATE = S_CLEAR;
`else
    localparam state_t ENTRY_STATE = S_RUN;
`endif

    state_t          state;
    logic [RW-1:0]   rr_ptr;
    logic [IW-1:0]   input_cnt;
    logic [PW-1:0]   pixel_cnt;
    logic [AW-1:0]   acq_cnt;
    logic            wr_bank;
    logic            rd_busy;

`ifdef HIS_BANK_CLEAR_EN
    logic [NB-1:0]   clr_bin;
    logic [PW-1:0]   clr_pix;
    logic            clr_end;
`endif

    logic [NB-1:0]   addr_arr [N_REQ];
    logic            sel_any;
    logic [RW-1:0]   sel_idx;
    logic            grant_ok;
    logic            frame_end;
    logic            handoff;

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_req
            assign addr_arr[gi] = req_addr[gi*NB +: NB];
            assign gnt[gi]      = grant_ok && (sel_idx == RW'(gi));
        end
    endgenerate

    // Round-robin search: first active requester at or after the pointer.
    always_comb begin
        int            cand;
        logic [RW-1:0] cand_idx;
        sel_any  = 1'b0;
        sel_idx  = '0;
        cand     = 0;
        cand_idx = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand     = (int'(rr_ptr) + k) % N_REQ;
            cand_idx = RW'(cand);
            if (!sel_any && req[cand_idx]) begin
                sel_any = 1'b1;
                sel_idx = cand_idx;
            end
        end
    end

    // A grant only leaves in RUN; reset suppresses it immediately.
    assign grant_ok  = (state == S_RUN) && sel_any && !res;
    assign frame_end = grant_ok && (input_cnt == IN_LAST) &&
                       (pixel_cnt == PIX_LAST) && (acq_cnt == ACQ_LAST);
    // Bank swap happens at frame end if readout is free (or frees now),
    // or later from WAIT when readout releases its bank.
    assign handoff   = (frame_end && (!rd_busy || rd_done)) ||
                       ((state == S_WAIT) && rd_done);
    assign stall     = (state == S_WAIT);

`ifndef HIS_BANK_CLEAR_EN
    assign ram_clr = 1'b0;
`endif

    // Scheduler FSM, position counters, bank bookkeeping and registered RAM strobes.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state      <= ENTRY_STATE;
            rr_ptr     <= '0;
            input_cnt  <= '0;
            pixel_cnt  <= '0;
            acq_cnt    <= '0;
            wr_bank    <= 1'b0;
            rd_busy    <= 1'b0;
            ram_we     <= 1'b0;
            ram_bank   <= 1'b0;
            ram_pix    <= '0;
            ram_bin    <= '0;
            rd_start   <= 1'b0;
            rd_bank    <= 1'b0;
            frame_done <= 1'b0;
`ifdef HIS_BANK_CLEAR_EN
            ram_clr    <= 1'b0;
            clr_bin    <= '0;
            clr_pix    <= '0;
            clr_end    <= 1'b0;
`endif
        end else begin
            ram_we     <= 1'b0;
            rd_start   <= 1'b0;
            frame_done <= 1'b0;
`ifdef HIS_BANK_CLEAR_EN
            ram_clr    <= 1'b0;
`endif

            // A fresh handoff keeps readout busy even if it releases now.
            if (handoff) begin
                rd_busy  <= 1'b1;
                rd_start <= 1'b1;
                rd_bank  <= wr_bank;
                wr_bank  <= ~wr_bank;
            end else if (rd_done) begin
                rd_busy  <= 1'b0;
            end

            case (state)
                S_RUN: begin
                    if (grant_ok) begin
                        ram_we   <= 1'b1;
                        ram_bin  <= addr_arr[sel_idx];
                        ram_pix  <= pixel_cnt;
                        ram_bank <= wr_bank;
                        rr_ptr   <= (sel_idx == REQ_LAST) ? '0 : sel_idx + 1'b1;

                        if (input_cnt == IN_LAST) begin
                            input_cnt <= '0;
                            if (pixel_cnt == PIX_LAST) begin
                                pixel_cnt <= '0;
                                if (acq_cnt == ACQ_LAST) acq_cnt <= '0;
                                else                     acq_cnt <= acq_cnt + 1'b1;
                            end else begin
                                pixel_cnt <= pixel_cnt + 1'b1;
                            end
                        end else begin
                            input_cnt <= input_cnt + 1'b1;
                        end

                        if (frame_end) begin
                            frame_done <= 1'b1;
                            state      <= handoff ? ENTRY_STATE : S_WAIT;
                        end
                    end
                end

                S_WAIT: begin
                    if (handoff) state <= ENTRY_STATE;
                end

`ifdef HIS_BANK_CLEAR_EN
                S_CLEAR: begin
                    // Bin is the fast index; one idle cycle after the last
                    // strobe keeps the first grant clear of the sweep.
                    if (!clr_end) begin
                        ram_clr  <= 1'b1;
                        ram_bank <= wr_bank;
                        ram_bin  <= clr_bin;
                        ram_pix  <= clr_pix;
                        if (clr_bin == {NB{1'b1}}) begin
                            clr_bin <= '0;
                            if (clr_pix == PIX_LAST) begin
                                clr_pix <= '0;
                                clr_end <= 1'b1;
                            end else begin
                                clr_pix <= clr_pix + 1'b1;
                            end
                        end else begin
                            clr_bin <= clr_bin + 1'b1;
                        end
                    end else begin
                        clr_end <= 1'b0;
                        state   <= S_RUN;
                    end
                end
`endif

                default: state <= S_RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_his_bank_scheduler.sv
// Bench for his_bank_scheduler: directed stimulus, a frame-level reference
// model checked every cycle, and literal expectations that pin the model.
// Works with or without HIS_BANK_CLEAR_EN defined for the whole build.
module tb_his_bank_scheduler;

    localparam int NR  = 4;
    localparam int NBB = 3;
    localparam int DN  = 2;
    localparam int PN  = 3;
    localparam int AN  = 2;
    localparam int FR  = DN * PN * AN;      // grants per frame (12)
    localparam int NBINS   = 1 << NBB;
    localparam int CLR_LEN = PN * NBINS;    // clear strobes (24)
`ifdef HIS_BANK_CLEAR_EN
    localparam bit CLR = 1'b1;
`else
    localparam bit CLR = 1'b0;
`endif
    localparam int M_RUN = 0, M_CLR = 1, M_WAIT = 2;

    logic              clk, res;
    logic [NR-1:0]     req;
    logic [NR*NBB-1:0] req_addr;
    logic [NR-1:0]     gnt;
    logic              ram_we, ram_clr, ram_bank;
    logic [1:0]        ram_pix;
    logic [NBB-1:0]    ram_bin;
    logic              rd_start, rd_bank, rd_done, frame_done, stall;

    his_bank_scheduler #(
        .N_REQ(NR), .NB(NBB), .DATA_NUM(DN), .PIXEL_NUM(PN), .ACQ_NUM(AN)
    ) dut (
        .clk(clk), .res(res), .req(req), .req_addr(req_addr), .gnt(gnt),
        .ram_we(ram_we), .ram_clr(ram_clr), .ram_bank(ram_bank),
        .ram_pix(ram_pix), .ram_bin(ram_bin), .rd_start(rd_start),
        .rd_bank(rd_bank), .rd_done(rd_done), .frame_done(frame_done),
        .stall(stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic timeout(input string name);
        total++;
        bad++;
        $display("FAIL %s: timeout waiting for DUT (cycle %0d)", name, cyc);
    endtask

    // ---------------- reference model (frame-level view) ----------------
    int   m_mode, m_ct, m_k, m_ptr;
    bit   m_bank, m_busy;
    bit   e_we, e_clr, e_rs, e_fd, e_rb, e_rbank;
    int   e_pix, e_bin;
    logic [NR-1:0] e_gnt;
    logic [NR-1:0] last_gnt;

    task automatic model_reset();
        m_mode = CLR ? M_CLR : M_RUN;
        m_ct = 0; m_k = 0; m_ptr = 0; m_bank = 0; m_busy = 0;
        e_we = 0; e_clr = 0; e_rs = 0; e_fd = 0; e_rb = 0; e_rbank = 0;
        e_pix = 0; e_bin = 0;
    endtask

    function automatic int pick(input logic [NR-1:0] r, input int p);
        for (int j = 0; j < NR; j++)
            if (r[(p + j) % NR]) return (p + j) % NR;
        return -1;
    endfunction

    // Outputs registered at the coming edge, from the frame-level view.
    task automatic advance(input int g);
        bit ho;
        ho = 0;
        e_we = 0; e_clr = 0; e_rs = 0; e_fd = 0;
        case (m_mode)
            M_RUN: if (g >= 0) begin
                e_we    = 1;
                e_bin   = int'(req_addr[g*NBB +: NBB]);
                e_pix   = (m_k / DN) % PN;
                e_rbank = m_bank;
                m_ptr   = (g + 1) % NR;
                m_k++;
                if (m_k == FR) begin
                    m_k  = 0;
                    e_fd = 1;
                    if (!m_busy || rd_done) ho = 1;
                    else m_mode = M_WAIT;
                end
            end
            M_WAIT: if (rd_done) ho = 1;
            default: begin
                if (m_ct < CLR_LEN) begin
                    e_clr = 1; e_rbank = m_bank;
                    e_bin = m_ct % NBINS; e_pix = m_ct / NBINS;
                    m_ct++;
                end else begin
                    m_ct = 0; m_mode = M_RUN;
                end
            end
        endcase
        if (ho) begin
            e_rs = 1; e_rb = m_bank; m_bank = !m_bank; m_busy = 1;
            m_mode = CLR ? M_CLR : M_RUN; m_ct = 0;
        end else if (rd_done) begin
            m_busy = 0;
        end
    endtask

    // Compare process: checks every output every cycle at the falling edge.
    initial begin
        int g;
        model_reset();
        last_gnt = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (res) model_reset();
            g = (m_mode == M_RUN && !res) ? pick(req, m_ptr) : -1;
            e_gnt = (g >= 0) ? NR'(1 << g) : '0;
            chk("gnt",        32'(gnt),        32'(e_gnt));
            chk("stall",      32'(stall),      32'(m_mode == M_WAIT));
            chk("ram_we",     32'(ram_we),     32'(e_we));
            chk("ram_clr",    32'(ram_clr),    32'(e_clr));
            chk("rd_start",   32'(rd_start),   32'(e_rs));
            chk("frame_done", 32'(frame_done), 32'(e_fd));
            chk("rd_bank",    32'(rd_bank),    32'(e_rb));
            if (e_we || e_clr) begin
                chk("ram_bank", 32'(ram_bank), 32'(e_rbank));
                chk("ram_pix",  32'(ram_pix),  32'(e_pix));
                chk("ram_bin",  32'(ram_bin),  32'(e_bin));
            end
            if (g >= 0)
                $display("cyc=%0d grant req=%0d bin=%0d frame_pos=%0d", cyc, g,
                         req_addr[g*NBB +: NBB], m_k);
            if (e_rs) $display("cyc=%0d handoff rd_bank=%0d", cyc + 1, e_rb);
            last_gnt = e_gnt;
            if (!res) advance(g);
        end
    end

    // ---------------- observation log for literal checks ----------------
    int gq[$];
    int pq[$];
    int rbq[$];
    int rs_we[$];
    int we_cnt = 0, clr_cnt = 0, stall_cnt = 0, rs1_fd = 0;
    bit after_rst = 0, first_seen = 0;
    int first_bank = -1, first_pix = -1;

    initial begin
        forever begin
            @(negedge clk);
            for (int j = 0; j < NR; j++) if (gnt[j] === 1'b1) gq.push_back(j);
            if (ram_we === 1'b1) begin
                we_cnt++;
                pq.push_back(int'(ram_pix));
                if (after_rst && !first_seen) begin
                    first_seen = 1; first_bank = int'(ram_bank); first_pix = int'(ram_pix);
                end
            end
            if (ram_clr === 1'b1) clr_cnt++;
            if (stall === 1'b1) stall_cnt++;
            if (rd_start === 1'b1) begin
                rbq.push_back(int'(rd_bank));
                rs_we.push_back(we_cnt);
                if (rbq.size() == 1) rs1_fd = int'(frame_done);
            end
        end
    end

    function automatic int qget(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    // ---------------- stimulus ----------------
    int gcount [NR];

    // One cycle of inputs: granted requesters drop, new ones join, the
    // address of a requester changes only after it has been served.
    task automatic step(input logic [NR-1:0] add, input bit rdd, input bit rd_on_last);
        @(posedge clk);
        #1;
        for (int j = 0; j < NR; j++) if (last_gnt[j]) gcount[j]++;
        req = (req & ~last_gnt) | add;
        for (int j = 0; j < NR; j++)
            req_addr[j*NBB +: NBB] = NBB'(j * 5 + gcount[j]);
        rd_done = rdd | (rd_on_last && m_mode == M_RUN && m_k == FR - 1 && req != '0);
    endtask

    task automatic run_until_rs(input int n, input logic [NR-1:0] add, input bit rol, input string name);
        int b;
        b = 0;
        while (rbq.size() < n && b < 400) begin step(add, 1'b0, rol); b++; end
        if (b >= 400) timeout(name);
    endtask

    task automatic run_until_wait(input string name);
        int b;
        b = 0;
        while (m_mode != M_WAIT && b < 400) begin step(4'hF, 1'b0, 1'b0); b++; end
        if (b >= 400) timeout(name);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got cycle %0d, required < 10000", cyc);
        $fatal(1);
    end

    initial begin
        int exp_g [12];
        int exp_p [12];
        int we_rel, b;
        logic [NR-1:0] pats [6];
        exp_g = '{0,1,2,3,0,1,2,3,0,1,2,3};
        exp_p = '{0,0,1,1,2,2,0,0,1,1,2,2};
        pats  = '{4'b1010, 4'b0001, 4'b0000, 4'b0110, 4'b1111, 4'b0100};
        for (int j = 0; j < NR; j++) gcount[j] = 0;
        res = 1'b1; req = '0; req_addr = '0; rd_done = 1'b0;
        repeat (3) @(posedge clk);
        #1 res = 1'b0;

        // Reset release: clear sweep (if built in), no grants.
        repeat (CLR ? 26 : 1) step(4'h0, 1'b0, 1'b0);
        chk("clear_strobe_count", 32'(clr_cnt), CLR ? 32'd24 : 32'd0);
        chk("no_grant_in_clear",  32'(gq.size()), 32'd0);

        // Frame 1: all requesters, readout idle -> immediate handoff of bank 0.
        run_until_rs(1, 4'hF, 1'b0, "frame1_rd_start");
        for (int i = 0; i < 12; i++) begin
            chk("rr_order",  32'(qget(gq, i)), 32'(exp_g[i]));
            chk("pix_order", 32'(qget(pq, i)), 32'(exp_p[i]));
        end
        chk("frame1_rd_bank",   32'(qget(rbq, 0)),   32'd0);
        chk("frame1_rs_at_w12", 32'(qget(rs_we, 0)), 32'd12);
        chk("frame1_done_with_rs", 32'(rs1_fd), 32'd1);

        // Frame 2: readout still busy -> WAIT for 5 cycles, then bank 1.
        stall_cnt = 0;
        run_until_wait("frame2_wait");
        repeat (3) step(4'hF, 1'b0, 1'b0);
        step(4'hF, 1'b1, 1'b0);
        repeat (2) step(4'hF, 1'b0, 1'b0);
        chk("frame2_stall_cycles", 32'(stall_cnt), 32'd5);
        chk("frame2_rd_bank", 32'(qget(rbq, 1)), 32'd1);

        // Frame 3: rd_done lands on the last grant -> no WAIT.
        stall_cnt = 0;
        run_until_rs(3, 4'hF, 1'b1, "frame3_rd_start");
        chk("frame3_no_stall", 32'(stall_cnt), 32'd0);
        chk("frame3_rd_bank",  32'(qget(rbq, 2)), 32'd0);

        // Frame 4: busy must have stayed set, so it waits again.
        stall_cnt = 0;
        run_until_wait("frame4_wait");
        step(4'hF, 1'b1, 1'b0);
        repeat (2) step(4'hF, 1'b0, 1'b0);
        chk("frame4_stall_cycles", 32'(stall_cnt), 32'd2);
        chk("frame4_rd_bank", 32'(qget(rbq, 3)), 32'd1);

        // Abort a frame after 5 grants with reset.
        b = 0;
        while (!(m_mode == M_RUN && m_k == 5) && b < 400) begin step(4'hF, 1'b0, 1'b0); b++; end
        if (b >= 400) timeout("reach_5_grants");
        res = 1'b1;
        #1;
        chk("rst_gnt",     32'(gnt),      32'd0);
        chk("rst_ram_we",  32'(ram_we),   32'd0);
        chk("rst_ram_pix", 32'(ram_pix),  32'd0);
        chk("rst_ram_bin", 32'(ram_bin),  32'd0);
        chk("rst_rd_bank", 32'(rd_bank),  32'd0);
        repeat (2) @(posedge clk);
        #1;
        after_rst = 1;
        we_rel = we_cnt;
        res = 1'b0;

        // Fresh frame with mixed request patterns; readout idle after reset.
        b = 0;
        while (rbq.size() < 5 && b < 400) begin step(pats[b % 6], 1'b0, 1'b0); b++; end
        if (b >= 400) timeout("frame5_rd_start");
        chk("post_rst_first_bank", 32'(first_bank), 32'd0);
        chk("post_rst_first_pix",  32'(first_pix),  32'd0);
        chk("frame5_rd_bank",      32'(qget(rbq, 4)), 32'd0);
        chk("frame5_full_frame",   32'(qget(rs_we, 4) - we_rel), 32'd12);
        repeat (3) step(4'h0, 1'b0, 1'b0);
        chk("handoff_count", 32'(rbq.size()), 32'd5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
